uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
Parametrised UART transmitter, the successor to the fixed 8N1 16x-oversampled transmitter.
- Data width, bit period, parity mode and stop-bit count are configurable.
- Source interface is valid/ready, replacing the FIFO read-strobe coupling.
- Supports gapless back-to-back frames and line-break generation.
- Sits between a TX FIFO (or any streaming source) and the pad.

Parameters:
DATA_WIDTH, 8, data bits per frame; legal 5..9; sent LSB first.
CLKS_PER_BIT, 16, clk cycles per bit period; legal >= 2; counter width = $clog2(CLKS_PER_BIT).

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
en  in  1  transmitter enable; gates acceptance only
cfg_parity_en  in  1  1 = append parity bit
cfg_parity_mode  in  2  00 even, 01 odd, 10 mark, 11 space
cfg_stop2  in  1  1 = two stop bits, 0 = one
send_break  in  1  level request: hold line low (break)
s_valid  in  1  source data valid
s_data  in  DATA_WIDTH  source data
s_ready  out  1  block accepts s_data this cycle
tx  out  1  serial line, idle high
busy  out  1  frame or break in progress
done  out  1  one-cycle pulse in the last cycle of a frame

Behaviour:
- Reset (rst=1 at posedge): state IDLE, tx=1, busy=0, done=0, all counters and shadow registers 0. s_ready=0 while rst=1. Applies mid-frame: tx=1 from the next cycle and the frame is abandoned, with no done.
- States: IDLE, START, DATA, PARITY, STOP, BREAK. Every bit state lasts exactly CLKS_PER_BIT cycles, counted by bit_cnt 0..CLKS_PER_BIT-1. The last cycle is bit_cnt==CLKS_PER_BIT-1.
- s_ready (combinational) = en & !send_break & !rst & (state==IDLE | frame_last). frame_last is the last cycle of the last stop bit of a data frame.
- Handshake: a transfer occurs when s_valid & s_ready at a posedge. On transfer, s_data, cfg_parity_en, cfg_parity_mode and cfg_stop2 are captured into shadow registers. Cfg changes mid-frame have no effect until the next transfer.
- Latency: on a transfer at edge T, tx=0 (START) from cycle T+1.
- START: tx=0 → DATA with bit index 0.
- DATA: tx=data[idx]. Increment idx at the end of each bit. After bit DATA_WIDTH-1, go to PARITY if parity_en, else STOP.
- PARITY: tx = ^data (even), ~^data (odd), 1 (mark), 0 (space) → STOP.
- STOP: tx=1, for 1 or 2 bit periods per the captured stop2.
- done=1 during frame_last only. In that same cycle, a transfer moves directly to START, giving a zero idle gap. Otherwise the block returns to IDLE.
- busy=1 in all states except IDLE.
- BREAK: entered from IDLE when send_break=1; send_break has priority over s_valid. tx=0 from the next cycle for as long as send_break=1.
  - On deassert: one STOP period (tx=1, single stop regardless of cfg), then IDLE.
  - Break never pulses done.
  - send_break asserted mid-frame is ignored until IDLE.
- en=0 mid-frame: the current frame completes normally; no new transfer is accepted.
- Frame length in cycles = CLKS_PER_BIT*(1 + DATA_WIDTH + parity_en + 1 + stop2).

Test Plan:
- 8N1 send (CLKS_PER_BIT=16): s_data=0xA5 accepted at T → tx=0 T+1..T+16; bits 1,0,1,0,0,1,0,1 each 16 cycles; tx=1 T+145..T+160; done=1 only at T+160; busy=0 at T+161.
- Parity: 0x07 with even → parity bit 1; odd → 0; mark → 1; space → 0. In each case the parity bit occupies cycles T+145..T+160 and the stop bit runs T+161..T+176.
- Two stop bits, DATA_WIDTH=5, s_data=0x1F → tx high for 32 cycles after the data bits; total frame 128 cycles; done at T+128.
- Back-to-back: s_valid held with 0x55 then 0xAA → second transfer in the first frame's done cycle; second start bit at T+161 with no idle gap; exactly two done pulses; cfg changed mid-frame applies only to the second frame.
- Break: send_break=1 for 100 cycles in IDLE (s_valid=1 throughout) → tx=0 for 100 cycles, then tx=1 for 16 cycles; s_ready=0 for the whole sequence; no done; the data is accepted afterwards.
- Reset mid-frame: rst=1 in DATA bit 3 → next cycle tx=1, busy=0, s_ready=1 (en=1); no done; the next frame transmits correctly.

Source files
------------

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start, DATA_WIDTH bits LSB first, optional parity, 1/2 stop; START on the line 1 cycle after accept.
// Backpressure: s_ready only in IDLE or the final stop cycle of a data frame (gapless chaining); break and en=0 hold it low.
module uart_tx_frame #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  cfg_parity_en,
    input  logic [1:0]            cfg_parity_mode,
    input  logic                  cfg_stop2,
    input  logic                  send_break,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  stop_idx_q, stop_idx_d;
    logic                  brk_q, brk_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_en_q, stop2_q;
    logic [1:0]            par_mode_q;
    logic                  cnt_last, frame_last, xfer, par_bit;

    assign cnt_last   = (bit_cnt_q == CNT_LAST);
    // brk_q marks the trailing stop period of a break, which must never look like a frame end
    assign frame_last = (state_q == STOP) && cnt_last && !brk_q && (stop_idx_q == stop2_q);
    assign s_ready    = en && !send_break && !rst && ((state_q == IDLE) || frame_last);
    assign xfer       = s_valid && s_ready;
    assign done       = frame_last;
    assign busy       = (state_q != IDLE);

    always_comb begin
        par_bit = 1'b0;
        case (par_mode_q)
            2'b00:   par_bit = ^data_q;
            2'b01:   par_bit = ~^data_q;
            2'b10:   par_bit = 1'b1;
            default: par_bit = 1'b0;
        endcase
    end

    always_comb begin
        tx = 1'b1;
        case (state_q)
            START, BREAK: tx = 1'b0;
            DATA:         tx = data_q[idx_q];
            PARITY:       tx = par_bit;
            default:      tx = 1'b1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        stop_idx_d = stop_idx_q;
        brk_d      = brk_q;
        bit_cnt_d  = cnt_last ? '0 : bit_cnt_q + 1'b1;
        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                if (send_break) begin
                    state_d = BREAK;
                    brk_d   = 1'b1;
                end else if (xfer) begin
                    state_d = START;
                    brk_d   = 1'b0;
                end
            end
            START: if (cnt_last) begin
                state_d = DATA;
                idx_d   = '0;
            end
            DATA: if (cnt_last) begin
                if (idx_q == IDX_LAST) begin
                    state_d    = par_en_q ? PARITY : STOP;
                    stop_idx_d = 1'b0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            PARITY: if (cnt_last) begin
                state_d    = STOP;
                stop_idx_d = 1'b0;
            end
            STOP: if (cnt_last) begin
                if (!brk_q && (stop_idx_q != stop2_q)) begin
                    stop_idx_d = 1'b1;
                end else if (xfer) begin
                    state_d = START;
                    brk_d   = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            BREAK: begin
                bit_cnt_d = '0;
                if (!send_break) begin
                    state_d    = STOP;
                    stop_idx_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            idx_q      <= '0;
            stop_idx_q <= 1'b0;
            brk_q      <= 1'b0;
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_mode_q <= 2'b00;
            stop2_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            idx_q      <= idx_d;
            stop_idx_q <= stop_idx_d;
            brk_q      <= brk_d;
            if (xfer) begin
                data_q     <= s_data;
                par_en_q   <= cfg_parity_en;
                par_mode_q <= cfg_parity_mode;
                stop2_q    <= cfg_stop2;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed and randomized frames for uart_tx_frame; every cycle compared against a bit-period model of the line.
module tb_uart_tx_frame;
    localparam int DW  = 8;
    localparam int CPB = 16;

    logic          clk, rst, en, cfg_parity_en, cfg_stop2, send_break, s_valid;
    logic [1:0]    cfg_parity_mode;
    logic [DW-1:0] s_data;
    logic          s_ready, tx, busy, done;
    logic [3:0]    obs;

    int total  = 0;
    int passed = 0;

    logic [7:0] nxt_d;
    logic       nxt_pe, nxt_s2;
    logic [1:0] nxt_pm;

    uart_tx_frame #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .en(en),
        .cfg_parity_en(cfg_parity_en), .cfg_parity_mode(cfg_parity_mode), .cfg_stop2(cfg_stop2),
        .send_break(send_break), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .tx(tx), .busy(busy), .done(done)
    );

    assign obs = {tx, busy, done, s_ready};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: {tx,busy,done,s_ready} got %b expected %b", tag, got, exp);
    endtask

    // Line level in cycle k (1-based) after the accepting edge, from the frame layout alone.
    function automatic logic model_tx(input logic [7:0] d, input logic pe, input logic [1:0] pm, input int k);
        int   b;
        logic odd;
        b   = (k - 1) / CPB;
        odd = ($countones(d) % 2) == 1;
        if (b == 0) return 1'b0;
        if (b <= DW) return d[b-1];
        if (pe && b == DW + 1) return (pm == 2'b00) ? odd : (pm == 2'b01) ? !odd : (pm == 2'b10);
        return 1'b1;
    endfunction

    task automatic launch(input logic [7:0] d, input logic pe, input logic [1:0] pm, input logic s2);
        s_valid = 1'b1; s_data = d;
        cfg_parity_en = pe; cfg_parity_mode = pm; cfg_stop2 = s2;
        #1;
        chk($sformatf("accept %h", d), obs, 4'b1001);
    endtask

    task automatic run_frame(input logic [7:0] d, input logic pe, input logic [1:0] pm, input logic s2,
                             input bit chain, input bit en_off, input bit brk_mid);
        int   len;
        logic etx, edone, erdy;
        len = CPB * (2 + DW + int'(pe) + int'(s2));
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            etx   = model_tx(d, pe, pm, k);
            edone = (k == len);
            erdy  = (k == len) && en && !send_break;
            chk($sformatf("frame %h cycle %0d", d, k), obs, {etx, 1'b1, edone, erdy});
            if (k == 1) begin
                if (chain) begin
                    s_data = nxt_d; cfg_parity_en = nxt_pe; cfg_parity_mode = nxt_pm; cfg_stop2 = nxt_s2;
                end else begin
                    s_valid = 1'b0; s_data = DW'($urandom);
                    cfg_parity_en = 1'($urandom); cfg_parity_mode = 2'($urandom); cfg_stop2 = 1'($urandom);
                end
                if (en_off) en = 1'b0;
                if (brk_mid) send_break = 1'b1;
            end
            if (k == len - 1) send_break = 1'b0;
        end
    endtask

    task automatic idle_chk(input string tag);
        @(negedge clk);
        chk(tag, obs, {1'b1, 1'b0, 1'b0, en && !send_break});
    endtask

    initial begin
        logic [7:0] d;
        logic       pe, s2, eo, bm;
        logic [1:0] pm;

        rst = 1'b1; en = 1'b1; send_break = 1'b0; s_valid = 1'b1; s_data = 8'hFF;
        cfg_parity_en = 1'b0; cfg_parity_mode = 2'b00; cfg_stop2 = 1'b0;
        nxt_d = 8'h00; nxt_pe = 1'b0; nxt_pm = 2'b00; nxt_s2 = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset", obs, 4'b1000);
        rst = 1'b0; s_valid = 1'b0;
        idle_chk("idle after reset");

        launch(8'hA5, 1'b0, 2'b00, 1'b0);
        run_frame(8'hA5, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_chk("idle after 8N1");

        for (int m = 0; m < 4; m++) begin
            launch(8'h07, 1'b1, 2'(m), 1'b0);
            run_frame(8'h07, 1'b1, 2'(m), 1'b0, 1'b0, 1'b0, 1'b0);
            idle_chk($sformatf("idle after parity mode %0d", m));
        end

        launch(8'h1F, 1'b0, 2'b00, 1'b1);
        run_frame(8'h1F, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        idle_chk("idle after two stop");

        nxt_d = 8'hAA; nxt_pe = 1'b1; nxt_pm = 2'b01; nxt_s2 = 1'b1;
        launch(8'h55, 1'b0, 2'b00, 1'b0);
        run_frame(8'h55, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        run_frame(8'hAA, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        idle_chk("idle after back-to-back");

        s_valid = 1'b1; s_data = 8'h3C; send_break = 1'b1;
        cfg_parity_en = 1'b0; cfg_parity_mode = 2'b00; cfg_stop2 = 1'b1;
        #1;
        chk("break request blocks ready", obs, 4'b1000);
        for (int k = 1; k <= 100 + CPB; k++) begin
            @(negedge clk);
            chk($sformatf("break cycle %0d", k), obs, {(k > 100), 1'b1, 1'b0, 1'b0});
            if (k == 100) send_break = 1'b0;
        end
        @(negedge clk);
        chk("ready after break", obs, 4'b1001);
        run_frame(8'h3C, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        idle_chk("idle after break frame");

        repeat (6) begin
            d = 8'($urandom); pe = 1'($urandom); pm = 2'($urandom); s2 = 1'($urandom);
            eo = ($urandom_range(0, 2) == 0); bm = ($urandom_range(0, 2) == 0);
            launch(d, pe, pm, s2);
            run_frame(d, pe, pm, s2, 1'b0, eo, bm);
            idle_chk($sformatf("idle after random %h", d));
            en = 1'b1;
        end

        launch(8'hC3, 1'b1, 2'b00, 1'b1);
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            chk($sformatf("pre-reset cycle %0d", k), obs, {model_tx(8'hC3, 1'b1, 2'b00, k), 3'b100});
            if (k == 1) s_valid = 1'b0;
        end
        rst = 1'b1;
        #1;
        chk("ready low in reset", {3'b000, s_ready}, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("after mid-frame reset", obs, 4'b1001);
        launch(8'h96, 1'b1, 2'b10, 1'b0);
        run_frame(8'h96, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_chk("idle after post-reset frame");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
